// File: rtl/upcntr_seq.sv
// Sequencer for the 2-bit up-counter: clear, then N increment pulses spaced by a gap, then done.
// Optional stall input enabled by defining UPCNTR_SEQ_PAUSE_EN.
module upcntr_seq #(
  parameter int CNT_W  = 2,
  parameter int STEP_W = 8,
  parameter int GAP_W  = 4
) (
  input  logic              clk,
  input  logic              reset,
`ifdef UPCNTR_SEQ_PAUSE_EN
  input  logic              pause,
`endif
  input  logic              start,
  input  logic [STEP_W-1:0] num_steps,
  input  logic [GAP_W-1:0]  gap,
  input  logic              abort,
  output logic              inc,
  output logic              cnt_clr,
  output logic              busy,
  output logic              done,
  output logic [STEP_W-1:0] steps_done,
  output logic [CNT_W-1:0]  cnt_mirror
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_CLR  = 3'd1,
    S_RUN  = 3'd2,
    S_GAP  = 3'd3,
    S_DONE = 3'd4
  } state_t;

  state_t              state_r, next_s;
  logic [STEP_W-1:0]   num_r, steps_r;
  logic [GAP_W-1:0]    gap_r, gcnt_r;
  logic [CNT_W-1:0]    mirror_r;
  logic                inc_r, cnt_clr_r, busy_r, done_r;
  logic                pause_s, kill_s, hold_s;
  logic                accept_s, fire_s, load_s, dec_s;

`ifdef UPCNTR_SEQ_PAUSE_EN
  assign pause_s = pause;
`else
  assign pause_s = 1'b0;
`endif

  assign kill_s = abort && (state_r != S_IDLE);
  assign hold_s = pause_s && ((state_r == S_RUN) || (state_r == S_GAP));

  // Next-state and per-cycle action strobes; abort beats pause, pause beats sequencing.
  always_comb begin
    next_s   = state_r;
    accept_s = 1'b0;
    fire_s   = 1'b0;
    load_s   = 1'b0;
    dec_s    = 1'b0;
    if (kill_s) begin
      next_s = S_IDLE;
    end else if (hold_s) begin
      next_s = state_r;
    end else begin
      case (state_r)
        S_IDLE: begin
          if (start) begin
            accept_s = 1'b1;
            if (num_steps == '0) begin
              next_s = S_DONE;
            end else begin
              next_s = S_CLR;
            end
          end else begin
            next_s = S_IDLE;
          end
        end
        S_CLR: begin
          next_s = S_RUN;
          fire_s = 1'b1;
        end
        S_RUN: begin
          if (steps_r == num_r) begin
            next_s = S_DONE;
          end else if (gap_r == '0) begin
            next_s = S_RUN;
            fire_s = 1'b1;
          end else begin
            next_s = S_GAP;
            load_s = 1'b1;
          end
        end
        // gcnt_r is never zero here: GAP is only entered with a non-zero load
        S_GAP: begin
          if (gcnt_r == GAP_W'(1)) begin
            next_s = S_RUN;
            fire_s = 1'b1;
          end else begin
            next_s = S_GAP;
            dec_s  = 1'b1;
          end
        end
        S_DONE: begin
          next_s = S_IDLE;
        end
        default: begin
          next_s = S_IDLE;
        end
      endcase
    end
  end

  // State register and registered pulse/status outputs, aligned with the state they describe.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_r   <= S_IDLE;
      inc_r     <= 1'b0;
      cnt_clr_r <= 1'b0;
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
    end else begin
      state_r   <= next_s;
      inc_r     <= fire_s;
      cnt_clr_r <= (next_s == S_CLR);
      busy_r    <= (next_s != S_IDLE);
      done_r    <= (next_s == S_DONE);
    end
  end

  // Operation parameters, gap countdown, progress count and shadow counter value.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      num_r    <= '0;
      gap_r    <= '0;
      gcnt_r   <= '0;
      steps_r  <= '0;
      mirror_r <= '0;
    end else begin
      if (accept_s) begin
        num_r   <= num_steps;
        gap_r   <= gap;
        steps_r <= '0;
      end else if (fire_s) begin
        steps_r <= steps_r + STEP_W'(1);
      end else begin
        steps_r <= steps_r;
      end
      if (next_s == S_CLR) begin
        mirror_r <= '0;
      end else if (fire_s) begin
        mirror_r <= mirror_r + CNT_W'(1);
      end else begin
        mirror_r <= mirror_r;
      end
      if (load_s) begin
        gcnt_r <= gap_r;
      end else if (dec_s) begin
        gcnt_r <= gcnt_r - GAP_W'(1);
      end else begin
        gcnt_r <= gcnt_r;
      end
    end
  end

  assign inc        = inc_r;
  assign cnt_clr    = cnt_clr_r;
  assign busy       = busy_r;
  assign done       = done_r;
  assign steps_done = steps_r;
  assign cnt_mirror = mirror_r;

endmodule

// File: tb/tb_upcntr_seq.sv
// Scoreboard bench for upcntr_seq: per-operation event timeline model feeding a queue,
// checked by an independent negedge monitor.
module tb_upcntr_seq;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic [7:0] num_steps = 8'd0;
  logic [3:0] gap = 4'd0;
`ifdef UPCNTR_SEQ_PAUSE_EN
  logic       pause = 1'b0;
`endif
  logic       inc, cnt_clr, busy, done;
  logic [7:0] steps_done;
  logic [1:0] cnt_mirror;

  upcntr_seq #(.CNT_W(2), .STEP_W(8), .GAP_W(4)) dut (
    .clk        (clk),
    .reset      (reset),
`ifdef UPCNTR_SEQ_PAUSE_EN
    .pause      (pause),
`endif
    .start      (start),
    .num_steps  (num_steps),
    .gap        (gap),
    .abort      (abort),
    .inc        (inc),
    .cnt_clr    (cnt_clr),
    .busy       (busy),
    .done       (done),
    .steps_done (steps_done),
    .cnt_mirror (cnt_mirror)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // kind: 0 = clear pulse, 1 = increment pulse, 2 = done pulse
  typedef struct {
    int t;
    int kind;
    int steps;
    int mirror;
  } ev_t;

  ev_t exp_q[$];
  int  checks = 0;
  int  errors = 0;
  int  busy_lo = 0;
  int  busy_hi = -1;
  int  steps_m = 0;
  int  mirror_m = 0;
  ev_t mon_e;
  int  mon_kind;

  function automatic void chk(string name, int got, int want);
    checks++;
    if (got != want) begin
      errors++;
      $display("FAIL %s at cycle %0d: got %0d, expected %0d", name, cyc, got, want);
    end
  endfunction

  // Monitor: busy window every cycle, and each presented pulse against the queue head.
  always @(negedge clk) begin
    chk("busy", int'(busy), (cyc >= busy_lo && cyc <= busy_hi) ? 1 : 0);
    while (exp_q.size() > 0 && exp_q[0].t < cyc) begin
      chk("missing_event_time", -1, exp_q[0].t);
      void'(exp_q.pop_front());
    end
    if (inc || cnt_clr || done) begin
      mon_kind = inc ? 1 : (cnt_clr ? 0 : 2);
      chk("one_pulse_at_a_time", int'(inc) + int'(cnt_clr) + int'(done), 1);
      if (exp_q.size() == 0) begin
        chk("unexpected_event_kind", mon_kind, -1);
      end else begin
        mon_e = exp_q.pop_front();
        chk("event_time", cyc, mon_e.t);
        chk("event_kind", mon_kind, mon_e.kind);
        chk("event_steps_done", int'(steps_done), mon_e.steps);
        chk("event_cnt_mirror", int'(cnt_mirror), mon_e.mirror);
      end
    end
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic int op_len(int n, int g);
    return (n == 0) ? 1 : 2 + n + (n - 1) * g;
  endfunction

  // One operation: ra = abort cycle relative to start (0 none), inj = start while busy,
  // ab_start = abort together with start, pp/pl = pause start cycle and length (0 none).
  task automatic run_op(input int n, input int g, input int ra, input bit inj,
                        input bit ab_start, input int pp, input int pl);
    int  t0, trel, tend;
    ev_t evs[$];
    ev_t e;
    t0 = cyc;
    start = 1'b1;
    abort = ab_start;
    num_steps = 8'(n);
    gap = 4'(g);
    trel = op_len(n, g);
    if (n > 0) begin
      e = '{t0 + 1, 0, 0, 0};
      evs.push_back(e);
      for (int k = 1; k <= n; k++) begin
        e = '{t0 + 2 + (k - 1) * (g + 1), 1, k, k % 4};
        evs.push_back(e);
      end
      e = '{t0 + trel, 2, n, n % 4};
    end else begin
      e = '{t0 + 1, 2, 0, mirror_m};
    end
    evs.push_back(e);
    if (pp > 0) begin
      foreach (evs[i]) if (evs[i].t > t0 + pp) evs[i].t += pl;
      trel += pl;
    end
    tend = (ra > 0) ? t0 + ra : t0 + trel;
    steps_m = 0;
    foreach (evs[i]) begin
      if (evs[i].t <= tend) begin
        exp_q.push_back(evs[i]);
        if (evs[i].kind != 2) begin
          steps_m  = evs[i].steps;
          mirror_m = evs[i].mirror;
        end
      end
    end
    busy_lo = t0 + 1;
    busy_hi = tend;
    tick();
    num_steps = 8'($urandom);
    gap = 4'($urandom);
    while (cyc <= tend) begin
      start = inj && (cyc == t0 + 2);
      abort = (ra > 0) && (cyc == t0 + ra);
`ifdef UPCNTR_SEQ_PAUSE_EN
      pause = (pp > 0) && (cyc >= t0 + pp) && (cyc < t0 + pp + pl);
`endif
      tick();
    end
    start = 1'b0;
    abort = 1'b0;
`ifdef UPCNTR_SEQ_PAUSE_EN
    pause = 1'b0;
`endif
    chk("pending_events_after_op", exp_q.size(), 0);
    chk("final_steps_done", int'(steps_done), steps_m);
    chk("final_cnt_mirror", int'(cnt_mirror), mirror_m);
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_inc"}, int'(inc), 0);
    chk({tag, "_cnt_clr"}, int'(cnt_clr), 0);
    chk({tag, "_busy"}, int'(busy), 0);
    chk({tag, "_done"}, int'(done), 0);
    chk({tag, "_steps_done"}, int'(steps_done), 0);
    chk({tag, "_cnt_mirror"}, int'(cnt_mirror), 0);
  endtask

  // Reset asserted while inc #3 of a 6-step run is showing; nothing may follow it.
  task automatic reset_mid;
    int  t0;
    ev_t e;
    t0 = cyc;
    start = 1'b1;
    num_steps = 8'd6;
    gap = 4'd0;
    e = '{t0 + 1, 0, 0, 0}; exp_q.push_back(e);
    e = '{t0 + 2, 1, 1, 1}; exp_q.push_back(e);
    e = '{t0 + 3, 1, 2, 2}; exp_q.push_back(e);
    busy_lo = t0 + 1;
    busy_hi = t0 + 3;
    tick();
    start = 1'b0;
    while (cyc < t0 + 4) tick();
    chk("pre_reset_steps_done", int'(steps_done), 3);
    #1 reset = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    steps_m = 0;
    mirror_m = 0;
    repeat (12) tick();
    chk("pending_events_after_reset", exp_q.size(), 0);
    check_reset_outputs("post_reset");
  endtask

  initial begin
    int n, g, ra;
    #1 reset = 1'b0;
    #2 check_reset_outputs("reset");
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    tick();

    run_op(5, 0, 0, 1'b0, 1'b0, 0, 0);   // basic, mirror wraps to 1
    tick();
    run_op(3, 2, 0, 1'b0, 1'b0, 0, 0);   // gap spacing
    run_op(0, 3, 0, 1'b0, 1'b0, 0, 0);   // zero steps
    run_op(4, 2, 6, 1'b0, 1'b0, 0, 0);   // abort in GAP after two incs
    run_op(6, 1, 0, 1'b1, 1'b0, 0, 0);   // start while busy ignored
    run_op(2, 0, 0, 1'b0, 1'b1, 0, 0);   // start with abort in IDLE accepted
    run_op(3, 15, 0, 1'b0, 1'b0, 0, 0);  // widest gap
    run_op(255, 0, 0, 1'b0, 1'b0, 0, 0); // maximum step count
`ifdef UPCNTR_SEQ_PAUSE_EN
    run_op(4, 1, 0, 1'b0, 1'b0, 3, 3);   // pause held 3 cycles in GAP
`endif
    reset_mid();

    for (int i = 0; i < 30; i++) begin
      n = $urandom_range(12, 0);
      g = $urandom_range(3, 0);
      ra = ($urandom_range(3, 0) == 0) ? $urandom_range(op_len(n, g), 1) : 0;
      run_op(n, g, ra, 1'($urandom_range(1, 0)), ($urandom_range(3, 0) == 0), 0, 0);
      repeat ($urandom_range(2, 0)) tick();
    end

    tick();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/upcntr_seq.md
Name: upcntr_seq

Overview:
Sequencer for the 2-bit up-counter datapath. On a start handshake it clears the counter, then issues a programmed number of single-cycle increment pulses, spaced by a programmable idle gap, and signals completion. It sits between control logic (or a testbench) and the counter's in/clear inputs. It also keeps a shadow copy of the expected counter value for checking.

Parameters:
CNT_W, 2, width of the driven counter and of the shadow value cnt_mirror
STEP_W, 8, width of the step-count request and progress counter
GAP_W, 4, width of the inter-increment gap setting

Ports:
clk  input  1  system clock; all logic on the rising edge
reset  input  1  asynchronous, active-low reset; forces every register to its reset value immediately
start  input  1  request pulse; sampled only in IDLE
num_steps  input  STEP_W  number of increments; captured when start is accepted
gap  input  GAP_W  idle cycles between increments; captured when start is accepted
abort  input  1  cancels the operation in any non-IDLE state
inc  output  1  increment pulse to the counter's in
cnt_clr  output  1  clear pulse to the counter
busy  output  1  high in every state except IDLE
done  output  1  single-cycle completion pulse
steps_done  output  STEP_W  increments issued so far in this operation
cnt_mirror  output  CNT_W  expected counter value, modulo 2^CNT_W

Behaviour:
- Reset values (reset low, asynchronous): state=IDLE; inc=0, cnt_clr=0, busy=0, done=0, steps_done=0, cnt_mirror=0; latched num_steps/gap=0.
- All outputs are registered. Every output change appears one cycle after the state or input that causes it.
- FSM states: IDLE, CLR, RUN, GAP, DONE.
- IDLE: busy=0.
  - On start=1: latch num_steps and gap, set steps_done=0.
  - If num_steps==0, go to DONE. Otherwise go to CLR.
- CLR: cnt_clr=1 for exactly one cycle, cnt_mirror<=0, then go to RUN.
- RUN: inc=1 for one cycle, steps_done+1, cnt_mirror+1 (wraps 3->0 at CNT_W=2).
  - If the new steps_done equals the latched num_steps, go to DONE.
  - Otherwise, if gap==0, stay in RUN (back-to-back inc).
  - Otherwise load the gap counter with gap and go to GAP.
- GAP: inc=0. The gap counter decrements each cycle; when it reaches 1, go to RUN. Exactly gap idle cycles separate consecutive inc pulses.
- DONE: done=1 for one cycle, busy=1, then go to IDLE. steps_done and cnt_mirror hold until the next accepted start.
- Latency: start to first inc = 2 cycles (CLR, then RUN). For N steps and gap G, start to done = 2 + N + (N-1)*G cycles.
- Priority: abort > start.
  - abort in CLR, RUN, GAP or DONE: go to IDLE next cycle. done is not asserted; inc and cnt_clr are 0 from that cycle. steps_done keeps the partial count.
  - abort in IDLE: ignored. If abort and start arrive together in IDLE, start is accepted.
- start while busy=1 is ignored; no queuing.
- num_steps and gap changes after acceptance have no effect.
- num_steps at its maximum (255) is legal; steps_done does not wrap within an operation.
- Reset asserted mid-operation returns everything to the reset values; no done is issued.

Optional Feature:
Macro UPCNTR_SEQ_PAUSE_EN.
- Defined: adds input port pause (1 bit).
  - pause=1 in RUN or GAP freezes the state, the gap counter, steps_done and cnt_mirror, and holds inc=0.
  - The sequence resumes where it stopped when pause drops.
  - abort overrides pause.
  - pause has no effect in IDLE, CLR or DONE.
- Not defined: no pause port exists and sequencing is never stalled.

Test Plan:
- Reset: hold reset=0 mid-sequence (steps_done=3) -> all outputs 0 immediately, state IDLE; no done after release.
- Basic run: start with num_steps=5, gap=0 -> cnt_clr at cycle 1, inc high on cycles 2-6 (one pulse per cycle), done at cycle 7, steps_done=5, cnt_mirror=1 (wrap 3->0).
- Gap spacing: num_steps=3, gap=2 -> inc at cycles 2, 5, 8, done at cycle 9; busy high for cycles 1-9.
- Zero steps: num_steps=0 -> no cnt_clr, no inc; done exactly one cycle after start.
- Abort and busy start: abort during GAP after 2 incs -> IDLE next cycle, no done, steps_done=2. A start issued mid-run is ignored; start together with abort in IDLE is accepted.
- Pause (UPCNTR_SEQ_PAUSE_EN): num_steps=4, gap=1, pause held 3 cycles in GAP -> gap timing is extended by exactly 3 cycles, still 4 inc pulses, done once.
